// File: rtl/div_clk_n.sv
// div_clk_n: runtime-programmable integer clock divider and period counter.
// Produces a divided waveform (po_clk), the phase within the current period
// (po_cnt) and a one-cycle tick on the first cycle of every period (po_tick).
// The divisor is only picked up while idle or at the end of a period, so a
// mid-period change never produces a short or stretched period.
//
// Optional build macro: DIV_CLK_N_ODD_DUTY50_EN
//   When defined, odd divisors get a 50% duty cycle by OR-ing in a copy of the
//   waveform delayed by half a clock (falling-edge flop).
//
// run | meaning
// ----+-----------------------------------------------------------
//  0  | idle: outputs held at 0, active follows clamp(div_n)
//  1  | running: po_cnt steps 0..active-1, reloads active at wrap

module div_clk_n #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_n,
  output logic [CNT_W-1:0] po_cnt,
  output logic             po_clk,
  output logic             po_tick
);

  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_DEFAULT < 2) ? CNT_W'(2) : CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half_n;
  logic             run;
  logic             po_clk_q;
  logic             at_wrap;

  // Clamp the requested divisor and derive the per-cycle compare values.
  always_comb begin
    div_clamped = (div_n < CNT_W'(2)) ? CNT_W'(2) : div_n;
    cnt_inc     = po_cnt + CNT_W'(1);
    half_n      = active >> 1;
    at_wrap     = (po_cnt == (active - CNT_W'(1)));
  end

  // Period counter, waveform and tick; en=0 always wins over everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_cnt   <= '0;
      po_clk_q <= 1'b0;
      po_tick  <= 1'b0;
      run      <= 1'b0;
      active   <= DIV_RST;
    end else if (!en) begin
      po_cnt   <= '0;
      po_clk_q <= 1'b0;
      po_tick  <= 1'b0;
      run      <= 1'b0;
      active   <= div_clamped;
    end else if (!run) begin
      // Start keeps the divisor captured during the last idle cycle.
      run      <= 1'b1;
      po_cnt   <= '0;
      po_clk_q <= 1'b1;
      po_tick  <= 1'b1;
    end else if (at_wrap) begin
      po_cnt   <= '0;
      po_clk_q <= 1'b1;
      po_tick  <= 1'b1;
      active   <= div_clamped;
    end else begin
      po_cnt   <= cnt_inc;
      po_tick  <= 1'b0;
      po_clk_q <= (cnt_inc < half_n);
    end
  end

`ifdef DIV_CLK_N_ODD_DUTY50_EN
  logic odd_q;
  logic neg_q;

  // Odd flag follows every load of active so it always describes the period in force.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd_q <= DIV_RST[0];
    end else if (!en) begin
      odd_q <= div_clamped[0];
    end else if (run && at_wrap) begin
      odd_q <= div_clamped[0];
    end
  end

  // Half-cycle delayed copy of the waveform used to stretch the high phase.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= po_clk_q;
    end
  end

  assign po_clk = odd_q ? (po_clk_q | neg_q) : po_clk_q;
`else
  assign po_clk = po_clk_q;
`endif

endmodule

// File: tb/tb_div_clk_n.sv
// Testbench for div_clk_n: directed scenarios plus randomized en/div_n traffic,
// checked against a period-level reference model (phase since period start,
// divisor latched per period).
`timescale 1ns/1ps

module tb_div_clk_n;

  localparam int CNT_W = 8;
  localparam time T_CLK = 20ns;

  logic             clk;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_n;
  logic [CNT_W-1:0] po_cnt;
  logic             po_clk;
  logic             po_tick;

  int n_chk;
  int n_pass;

  // reference model state
  bit running;
  int phase;
  int cur_n;
  bit m_clk;
  bit m_clk_prev;

  div_clk_n #(.CNT_W(CNT_W), .DIV_DEFAULT(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_n   (div_n),
    .po_cnt  (po_cnt),
    .po_clk  (po_clk),
    .po_tick (po_tick)
  );

  initial clk = 1'b0;
  always #(T_CLK/2) clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int clamp2(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic model_reset();
    running    = 0;
    phase      = 0;
    cur_n      = 4;
    m_clk      = 0;
    m_clk_prev = 0;
  endtask

  // One clock of the reference: the waveform is high for the first
  // floor(n/2) cycles of each n-cycle period.
  task automatic model_edge(input bit e, input int d);
    m_clk_prev = m_clk;
    if (!e) begin
      running = 0;
      phase   = 0;
      cur_n   = clamp2(d);
    end else if (!running) begin
      running = 1;
      phase   = 0;
    end else begin
      phase++;
      if (phase == cur_n) begin
        phase = 0;
        cur_n = clamp2(d);
      end
    end
    m_clk = running && (phase < cur_n / 2);
  endtask

  function automatic bit exp_clk();
`ifdef DIV_CLK_N_ODD_DUTY50_EN
    return (cur_n % 2 == 1) ? (m_clk | m_clk_prev) : m_clk;
`else
    return m_clk;
`endif
  endfunction

  task automatic step(input bit e, input int d);
    en    = e;
    div_n = CNT_W'(d);
    @(posedge clk);
    model_edge(e, d);
    #1;
    chk("po_cnt", int'(po_cnt), running ? phase : 0);
    chk("po_tick", int'(po_tick), (running && phase == 0) ? 1 : 0);
    chk("po_clk", int'(po_clk), int'(exp_clk()));
  endtask

  // Reset applied between clock edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #5;
    rst = 1'b1;
    #1;
    chk("rst_cnt", int'(po_cnt), 0);
    chk("rst_clk", int'(po_clk), 0);
    chk("rst_tick", int'(po_tick), 0);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  // Wait (bounded) for po_clk to reach level lvl; returns the time it did.
  task automatic wait_lvl(input bit lvl, output time t, output bit ok);
    ok = 0;
    t  = 0;
    for (int i = 0; i < 400; i++) begin
      if (po_clk == lvl) begin
        ok = 1;
        t  = $time;
        break;
      end
      #1;
    end
  endtask

  initial begin
    int  ticks;
    int  guard;
    bit  ok0, ok1, ok2, ok3;
    time t0, t1, t2, tx;

    n_chk  = 0;
    n_pass = 0;
    model_reset();
    rst   = 1'b1;
    en    = 1'b1;
    div_n = 8'd4;
    #100ns;
    chk("reset_cnt", int'(po_cnt), 0);
    chk("reset_clk", int'(po_clk), 0);
    chk("reset_tick", int'(po_tick), 0);
    #1;
    rst = 1'b0;

    // Default divisor: tick every 4 cycles
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 4);
      ticks += int'(po_tick);
    end
    chk("ticks_n4", ticks, 3);

    // Runtime change 4 -> 6 requested at po_cnt=1
    guard = 0;
    while (po_cnt != 8'd1 && guard < 10) begin
      step(1, 4);
      guard++;
    end
    chk("sync_cnt1", int'(po_cnt), 1);
    for (int i = 0; i < 14; i++) step(1, 6);
    chk("n_after_change", cur_n, 6);

    // Clamp 0 and 1 to 2
    for (int i = 0; i < 8; i++) step(1, 0);
    for (int i = 0; i < 8; i++) step(1, 1);

    // Enable abort at po_cnt=2 with N=8
    for (int i = 0; i < 3; i++) step(0, 8);
    step(1, 8);
    step(1, 8);
    step(1, 8);
    chk("abort_at2", int'(po_cnt), 2);
    step(0, 8);
    step(1, 8);
    chk("restart_tick", int'(po_tick), 1);
    for (int i = 0; i < 10; i++) step(1, 8);

    // Async reset at po_cnt=5, N=8; active returns to the default 4
    guard = 0;
    while (po_cnt != 8'd5 && guard < 20) begin
      step(1, 8);
      guard++;
    end
    chk("sync_cnt5", int'(po_cnt), 5);
    pulse_reset();
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 9);
      ticks += int'(po_tick);
    end
    chk("ticks_after_rst", ticks, 2);

    // Odd divisor N=5: measure high/low time of po_clk
    step(0, 5);
    for (int i = 0; i < 12; i++) step(1, 5);
    wait_lvl(1'b0, tx, ok0);
    wait_lvl(1'b1, t0, ok1);
    wait_lvl(1'b0, t1, ok2);
    wait_lvl(1'b1, t2, ok3);
    chk("duty_timeout", int'(ok0 & ok1 & ok2 & ok3), 1);
`ifdef DIV_CLK_N_ODD_DUTY50_EN
    chk("n5_high_ns", int'(t1 - t0), 50);
    chk("n5_low_ns", int'(t2 - t1), 50);
`else
    chk("n5_high_ns", int'(t1 - t0), 40);
    chk("n5_low_ns", int'(t2 - t1), 60);
`endif
    pulse_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit e;
      int d;
      e = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 3);
      else d = $urandom_range(0, 12);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step(e, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
